inpkt_v2: RTL



---
 rtl/inpkt_v2_pkg.sv | 20 ++
 rtl/inpkt_v2_checksum.sv | 23 ++
 rtl/inpkt_v2.sv | 128 ++++++++++++
 3 files changed

// File: rtl/inpkt_v2_pkg.sv
// inpkt_v2_pkg: shared constants, error codes and state encoding for the inbound packet parser
package inpkt_v2_pkg;
  localparam logic [7:0] TYPE_D1 = 8'hD1;
  localparam logic [7:0] TYPE_D2 = 8'hD2;
  localparam logic [7:0] TYPE_D3 = 8'hD3;
  localparam int HEADER_LEN = 10;
  localparam int CHECKSUM_LEN = 4;
  localparam logic [14:0] HDR_WORDS = 15'(HEADER_LEN / 2);
  localparam logic [14:0] CKS_WORDS = 15'(CHECKSUM_LEN / 2);
  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_VERSION = 3'd1;
  localparam logic [2:0] ERR_TYPE = 3'd2;
  localparam logic [2:0] ERR_LEN = 3'd3;
  localparam logic [2:0] ERR_HCKS = 3'd4;
  localparam logic [2:0] ERR_DCKS = 3'd5;
  typedef enum logic [2:0] {HDR, HCKS, DATA, DCKS, ERROR} state_t;
  function automatic logic valid_type(input logic [7:0] t);
    return t == TYPE_D1 || t == TYPE_D2 || t == TYPE_D3;
  endfunction
endpackage

// File: rtl/inpkt_v2_checksum.sv
// inpkt_v2_checksum: 32-bit word-sum accumulator; match when the two trailing words equal ~sum
module inpkt_v2_checksum (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        add,
  input  logic        lo_ld,
  input  logic [15:0] din,
  output logic        match
);
  logic [31:0] sum;
  logic [15:0] lo;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sum <= '0;
      lo <= '0;
    end else begin
      sum <= clr ? '0 : add ? sum + {16'd0, din} : sum;
      lo <= lo_ld ? din : lo;
    end
  // checksum arrives low word first, so the high word is compared live from din
  assign match = {din, lo} == ~sum;
endmodule

// File: rtl/inpkt_v2.sv
// inpkt_v2: parses 16-bit FIFO words into header fields and a cut-through payload stream.
// Checksums are verified only when INPKT_CHECKSUM_EN is defined; otherwise they are consumed and ignored.
module inpkt_v2
  import inpkt_v2_pkg::*;
#(
  parameter int VERSION = 1,
  parameter int PKT_TYPE_MSB = 1,
  parameter int PKT_MAX_LEN = 16384
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [15:0]           din,
  input  logic                  empty,
  output logic                  rd_en,
  output logic [PKT_TYPE_MSB:0] pkt_type,
  output logic [15:0]           pkt_id,
  output logic [15:0]           pkt_len,
  output logic                  pkt_start,
  output logic [15:0]           dout,
  output logic                  wr_en,
  input  logic                  full,
  output logic                  pkt_end,
  output logic                  pkt_done,
  output logic                  err,
  output logic [2:0]            err_code
);
  localparam int TW = PKT_TYPE_MSB + 1;
  state_t state;
  logic [14:0] cnt;
  logic [1:0] hdr_type;
  logic [15:0] hdr_len;
  logic [15:0] hdr_id;
  logic [2:0] hdr_code;
  logic cks_ok;
  logic last;
  assign rd_en = ~empty & (state != ERROR) & ((state != DATA) | ~full);
  assign wr_en = rd_en & (state == DATA);
  assign dout = (state == DATA) ? din : '0;
  assign last = cnt == pkt_len[15:1] - 15'd1;
  assign pkt_end = wr_en & last;
  // checks for the header word currently on din; only acted on while in HDR
  assign hdr_code = (cnt == 15'd0) ? ((din[7:0] != 8'(VERSION)) ? ERR_VERSION :
                                      !valid_type(din[15:8]) ? ERR_TYPE : ERR_NONE) :
                    (cnt == 15'd2) ? ((din == 16'd0 || din[0] || 32'(din) > 32'(PKT_MAX_LEN)) ? ERR_LEN : ERR_NONE) :
                    (cnt == 15'd3 && din != 16'd0) ? ERR_LEN : ERR_NONE;
`ifdef INPKT_CHECKSUM_EN
  inpkt_v2_checksum u_cks (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (rd_en & (state == HCKS || state == DCKS) & (cnt == CKS_WORDS - 15'd1)),
    .add   (rd_en & (state == HDR || state == DATA)),
    .lo_ld (rd_en & (state == HCKS || state == DCKS) & (cnt == 15'd0)),
    .din   (din),
    .match (cks_ok)
  );
`else
  assign cks_ok = 1'b1;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= HDR;
      cnt <= '0;
      hdr_type <= '0;
      hdr_len <= '0;
      hdr_id <= '0;
      pkt_type <= '0;
      pkt_id <= '0;
      pkt_len <= '0;
      pkt_start <= 1'b0;
      pkt_done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      pkt_start <= 1'b0;
      pkt_done <= 1'b0;
      if (rd_en) begin
        cnt <= cnt + 15'd1;
        case (state)
          HDR: begin
            if (cnt == 15'd0) hdr_type <= din[9:8];
            if (cnt == 15'd2) hdr_len <= din;
            if (cnt == 15'd4) hdr_id <= din;
            if (hdr_code != ERR_NONE) begin
              state <= ERROR;
              err <= 1'b1;
              err_code <= hdr_code;
            end else if (cnt == HDR_WORDS - 15'd1) begin
              state <= HCKS;
              cnt <= '0;
            end
          end
          HCKS:
            if (cnt == CKS_WORDS - 15'd1) begin
              cnt <= '0;
              if (cks_ok) begin
                state <= DATA;
                pkt_start <= 1'b1;
                pkt_type <= TW'(hdr_type);
                pkt_id <= hdr_id;
                pkt_len <= hdr_len;
              end else begin
                state <= ERROR;
                err <= 1'b1;
                err_code <= ERR_HCKS;
              end
            end
          DATA:
            if (last) begin
              state <= DCKS;
              cnt <= '0;
            end
          DCKS:
            if (cnt == CKS_WORDS - 15'd1) begin
              cnt <= '0;
              if (cks_ok) begin
                state <= HDR;
                pkt_done <= 1'b1;
              end else begin
                state <= ERROR;
                err <= 1'b1;
                err_code <= ERR_DCKS;
              end
            end
          default: ;
        endcase
      end
    end
endmodule
